prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAX_WORDS, 128, maximum instruction words per load (8-bit byte address space / 2).
REQ-002 Parameter: BASE_ADDR, 8'h00, byte address of first instruction word written.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  byte stream valid.
REQ-007 in_data  input  8  byte stream payload.
REQ-008 in_ready  output  1  loader accepts byte when in_valid && in_ready.
REQ-009 im_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 im_addr  output  8  byte address of word being written, always even.
REQ-011 im_wdata  output  16  instruction word; [7:0] op/regs, [15:8] immediate.
REQ-012 cpu_rst  output  1  holds CPU core in reset while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted.
REQ-015 words_loaded  output  8  count of words written in current/last load.

Function
REQ-016 States SHALL be IDLE, LEN, DATA_LO, DATA_HI, CHK (macro only), DONE, ERR.
REQ-017 in_ready SHALL be 1 only in LEN, DATA_LO, DATA_HI, CHK; 0 elsewhere.
REQ-018 start in IDLE, DONE or ERR SHALL go to LEN, clear done/err/words_loaded, assert cpu_rst next cycle; start in other states SHALL be ignored.
REQ-019 LEN: accepted byte N; N==0 or N>MAX_WORDS -> ERR; else latch N -> DATA_LO.
REQ-020 DATA_LO: accepted byte latched as word[7:0] -> DATA_HI.
REQ-021 DATA_HI: accepted byte forms word[15:8]; next cycle im_we=1 for exactly one cycle, im_addr=BASE_ADDR+2*k (k = word index, mod 256), im_wdata=word, words_loaded increments.
REQ-022 After word k<N-1 -> DATA_LO; after word N-1 -> DONE (or CHK with macro).
REQ-023 DONE SHALL set done=1 and cpu_rst=0 one cycle after final im_we pulse; held until start or rst.
REQ-024 ERR SHALL set err=1, keep cpu_rst=1, no further im_we; held until start or rst.
REQ-025 in_valid low SHALL stall in place with no timeout; no byte lost or duplicated.
REQ-026 im_we, im_addr, im_wdata SHALL be registered outputs; im_we=0 outside write cycles.
REQ-027 Simultaneous start and in_valid in IDLE/DONE/ERR: byte SHALL NOT be accepted (in_ready=0).

Reset
REQ-028 rst SHALL force IDLE, cpu_rst=1, in_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, err=0, words_loaded=0 immediately.
REQ-029 rst mid-load SHALL abort; partial memory contents are not restored.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: after last word, CHK accepts one trailer byte; 8-bit sum of N, all data bytes and trailer ==0 -> DONE, else ERR.
REQ-031 Macro undefined: no CHK state, no trailer byte, DONE follows last word directly.

Structure
REQ-032 Package prog_loader_pkg SHALL hold the state enum typedef and default MAX_WORDS/BASE_ADDR constants.
REQ-033 One sub-module, prog_loader_csum (8-bit running-sum accumulator with clear), SHALL be instantiated only under PROG_LOADER_CHECKSUM_EN.

Verification
REQ-034 start; bytes 02,10,05,A0,0C -> im_we at addr 00 data 0510, addr 02 data 0CA0; done=1, cpu_rst=0, words_loaded=2.
REQ-035 start; length byte 00 -> err=1, cpu_rst=1, no im_we; then start, valid 1-word load -> done=1.
REQ-036 in_valid toggled 1-0-0-1 per byte for a 3-word load -> same writes as contiguous stream, no duplicates.
REQ-037 rst asserted after 3 of 5 bytes -> IDLE, all outputs at reset values same cycle.
REQ-038 Macro on: 01,34,12 then trailer B9 -> done=1; trailer B8 -> err=1.
REQ-039 BASE_ADDR=FE, 2 words -> addresses FE then 00 (wrap).

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared definitions for the program loader.
//   state_t         : loader FSM state encoding
//   DEF_MAX_WORDS   : default maximum words per load
//   DEF_BASE_ADDR   : default byte address of the first word
//   word_addr()     : byte address of word k, wrapping modulo 256
package prog_loader_pkg;

   localparam int         DEF_MAX_WORDS = 128;
   localparam logic [7:0] DEF_BASE_ADDR = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA_LO,
      ST_DATA_HI,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_t;

   // Words are 2 bytes wide, so word k lives at base + 2k; the 8-bit sum
   // wraps naturally past 8'hFF.
   function automatic logic [7:0] word_addr(input logic [7:0] base,
                                            input logic [7:0] idx);
      return base + {idx[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// prog_loader_csum -- 8-bit running-sum accumulator with synchronous clear.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : zero the sum (takes priority over en)
//   en       : add data into the sum
//   data     : byte to accumulate
//   sum      : current modulo-256 sum
module prog_loader_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum <= 8'h00;
      else if (clr)
         sum <= 8'h00;
      else if (en)
         sum <= sum + data;
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader -- loads a length-prefixed byte stream into instruction memory
// while holding the CPU core in reset.
// Stream: length byte N (1..MAX_WORDS), then N little-endian 16-bit words.
// With PROG_LOADER_CHECKSUM_EN defined, one trailer byte follows the words;
// the 8-bit sum of N, every data byte and the trailer must be zero.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle request to begin a load (ignored mid-load)
//   in_valid/in_data/in_ready : byte stream handshake
//   im_we/im_addr/im_wdata    : registered instruction memory write port
//   cpu_rst       : holds the CPU in reset until a load completes
//   done, err     : load completed / aborted (sticky until start or rst)
//   words_loaded  : words written in the current or last load
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         MAX_WORDS = DEF_MAX_WORDS,
   parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_we,
   output logic [7:0]  im_addr,
   output logic [15:0] im_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err,
   output logic [7:0]  words_loaded
);

   localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

   state_t     state;
   logic [7:0] len_q;
   logic [7:0] lo_byte;
   logic       accept;
   logic       len_bad;
   logic       last_word;
   logic       can_start;

   assign accept    = in_valid && in_ready;
   assign len_bad   = (in_data == 8'h00) || ({1'b0, in_data} > MAX_W9);
   assign last_word = ((words_loaded + 8'd1) == len_q);
   assign can_start = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);

   // in_ready decodes directly from the state register, so it drops the
   // moment reset is applied and is never high while a start is pending.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         ST_LEN, ST_DATA_LO, ST_DATA_HI: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
         ST_CHK:                         in_ready = 1'b1;
`endif
         default:                        in_ready = 1'b0;
      endcase
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_ok;

   // Sum covers the length byte and all data bytes; the trailer is added
   // combinationally when it arrives.
   prog_loader_csum u_csum (
      .clk  (clk),
      .rst  (rst),
      .clr  (start && can_start),
      .en   (accept && (state != ST_CHK)),
      .data (in_data),
      .sum  (csum)
   );

   assign csum_ok = ((csum + in_data) == 8'h00);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         len_q        <= 8'h00;
         lo_byte      <= 8'h00;
         im_we        <= 1'b0;
         im_addr      <= 8'h00;
         im_wdata     <= 16'h0000;
         cpu_rst      <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= 8'h00;
      end else begin
         im_we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state        <= ST_LEN;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  words_loaded <= 8'h00;
                  cpu_rst      <= 1'b1;
               end else if (state == ST_DONE) begin
                  // Flags follow the state by one cycle, which places done
                  // one cycle after the final write strobe.
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
               end else if (state == ST_ERR) begin
                  err <= 1'b1;
               end
            end
            ST_LEN: begin
               if (accept) begin
                  if (len_bad) begin
                     state <= ST_ERR;
                  end else begin
                     len_q <= in_data;
                     state <= ST_DATA_LO;
                  end
               end
            end
            ST_DATA_LO: begin
               if (accept) begin
                  lo_byte <= in_data;
                  state   <= ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               if (accept) begin
                  im_we        <= 1'b1;
                  im_addr      <= word_addr(BASE_ADDR, words_loaded);
                  im_wdata     <= {in_data, lo_byte};
                  words_loaded <= words_loaded + 8'd1;
                  if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     state <= ST_CHK;
`else
                     state <= ST_DONE;
`endif
                  end else begin
                     state <= ST_DATA_LO;
                  end
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (accept)
                  state <= csum_ok ? ST_DONE : ST_ERR;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- randomized self-checking bench for prog_loader.
// Two instances share one stimulus stream: BASE_ADDR 8'h00 and 8'hFE (the
// latter exercises address wrap). Expected writes and flags come from a
// reference model working on whole byte lists. Define
// PROG_LOADER_CHECKSUM_EN for both RTL and bench to cover the trailer byte.
module tb_prog_loader;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        in_ready_a, im_we_a, cpu_rst_a, done_a, err_a;
   logic [7:0]  im_addr_a, words_loaded_a;
   logic [15:0] im_wdata_a;
   logic        in_ready_b, im_we_b, cpu_rst_b, done_b, err_b;
   logic [7:0]  im_addr_b, words_loaded_b;
   logic [15:0] im_wdata_b;

   int n_checks = 0;
   int n_errors = 0;

   wr_t wr_a[$];
   wr_t wr_b[$];

   prog_loader #(.MAX_WORDS(128), .BASE_ADDR(8'h00)) dut_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_a), .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
      .cpu_rst(cpu_rst_a), .done(done_a), .err(err_a), .words_loaded(words_loaded_a)
   );

   prog_loader #(.MAX_WORDS(128), .BASE_ADDR(8'hFE)) dut_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_b), .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
      .cpu_rst(cpu_rst_b), .done(done_b), .err(err_b), .words_loaded(words_loaded_b)
   );

   always #5 clk = ~clk;

   // Write monitor: strobes are registered, so mid-cycle sampling is stable.
   always @(negedge clk) begin
      if (!rst) begin
         if (im_we_a) wr_a.push_back('{addr: im_addr_a, data: im_wdata_a});
         if (im_we_b) wr_b.push_back('{addr: im_addr_b, data: im_wdata_b});
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready_a), 32'd0);
      chk({tag, "_cpu_rst"},  32'(cpu_rst_a),  32'd1);
      chk({tag, "_im_we"},    32'(im_we_a),    32'd0);
      chk({tag, "_im_addr"},  32'(im_addr_a),  32'd0);
      chk({tag, "_im_wdata"}, 32'(im_wdata_a), 32'd0);
      chk({tag, "_done"},     32'(done_a),     32'd0);
      chk({tag, "_err"},      32'(err_a),      32'd0);
      chk({tag, "_words"},    32'(words_loaded_a), 32'd0);
      chk({tag, "_b_addr"},   32'(im_addr_b),  32'd0);
   endtask

   // All driving tasks begin and end shortly after a rising edge.
   task automatic pulse_start(input string tag);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_start_cpu_rst"}, 32'(cpu_rst_a), 32'd1);
      chk({tag, "_start_ready"},   32'(in_ready_a), 32'd1);
      chk({tag, "_start_words"},   32'(words_loaded_a), 32'd0);
      chk({tag, "_start_done"},    32'({done_a, err_a}), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
      bit ok;
      in_valid = 1'b0;
      repeat (gap) begin
         in_data = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int g = 0; g < 20 && !ok; g++) begin
         @(negedge clk);
         if (in_ready_a) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!ok) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   // Full load: model derives the expected writes and final flags from the
   // length byte and data list, then the stream is driven and compared.
   task automatic do_load(input logic [7:0] n, input logic [7:0] data[$],
                          input int gap_lo, input int gap_hi,
                          input bit corrupt, input string tag);
      bit         len_ok;
      bit         exp_ok;
      int         exp_words;
      int         nw;
      bit         fin;
      logic [7:0] sum;
      wr_t        ea[$];
      wr_t        eb[$];

      len_ok = (n >= 8'd1) && (int'(n) <= 128);
      nw     = len_ok ? int'(n) : 0;
`ifdef PROG_LOADER_CHECKSUM_EN
      exp_ok = len_ok && !corrupt;
`else
      exp_ok = len_ok;
`endif
      exp_words = nw;
      for (int k = 0; k < nw; k++) begin
         ea.push_back('{addr: 8'(2 * k),       data: {data[2*k+1], data[2*k]}});
         eb.push_back('{addr: 8'(254 + 2 * k), data: {data[2*k+1], data[2*k]}});
      end

      wr_a.delete();
      wr_b.delete();
      pulse_start(tag);
      send_byte(n, $urandom_range(gap_hi, gap_lo), tag);
      sum = n;
      for (int i = 0; i < 2 * nw; i++) begin
         send_byte(data[i], $urandom_range(gap_hi, gap_lo), tag);
         sum = sum + data[i];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (len_ok)
         send_byte(corrupt ? (8'h00 - sum - 8'h01) : (8'h00 - sum),
                   $urandom_range(gap_hi, gap_lo), tag);
`endif

      fin = 1'b0;
      for (int c = 0; c < 30 && !fin; c++) begin
         @(negedge clk);
         fin = done_a || err_a;
      end
      if (!fin) chk({tag, "_finish_timeout"}, 32'd0, 32'd1);

      chk({tag, "_done"},     32'(done_a),  32'(exp_ok));
      chk({tag, "_err"},      32'(err_a),   32'(!exp_ok));
      chk({tag, "_cpu_rst"},  32'(cpu_rst_a), 32'(!exp_ok));
      chk({tag, "_words"},    32'(words_loaded_a), 32'(exp_words));
      chk({tag, "_ready"},    32'(in_ready_a), 32'd0);
      chk({tag, "_we_idle"},  32'(im_we_a), 32'd0);
      chk({tag, "_b_done"},   32'({done_b, err_b}), 32'({exp_ok, !exp_ok}));
      chk({tag, "_n_wr_a"},   32'(wr_a.size()), 32'(ea.size()));
      chk({tag, "_n_wr_b"},   32'(wr_b.size()), 32'(eb.size()));
      for (int k = 0; k < ea.size() && k < wr_a.size(); k++) begin
         chk({tag, "_addr_a"}, 32'(wr_a[k].addr), 32'(ea[k].addr));
         chk({tag, "_data_a"}, 32'(wr_a[k].data), 32'(ea[k].data));
      end
      for (int k = 0; k < eb.size() && k < wr_b.size(); k++)
         chk({tag, "_addr_b"}, 32'(wr_b[k].addr), 32'(eb[k].addr));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] d[$];
      logic [7:0] n;
      int         r;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", 32'(in_ready_a), 32'd0);

      // Two-word reference load.
      d = '{8'h10, 8'h05, 8'hA0, 8'h0C};
      do_load(8'h02, d, 0, 0, 1'b0, "two_word");
      chk("two_word_w0", 32'(wr_a.size() > 0 ? wr_a[0].data : 16'h0), 32'h0510);
      chk("two_word_w1", 32'(wr_a.size() > 1 ? wr_a[1].data : 16'h0), 32'h0CA0);

      // start together with a valid byte from DONE: byte must not be taken.
      start = 1'b1; in_valid = 1'b1; in_data = 8'h05;
      #1;
      chk("start_valid_ready", 32'(in_ready_a), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      d = '{8'h11, 8'h22};
      do_load(8'h01, d, 0, 1, 1'b0, "after_sim_start");

      // Zero length aborts, then a good load recovers.
      d = {};
      do_load(8'h00, d, 0, 0, 1'b0, "len_zero");
      d = '{8'h3C, 8'hC3};
      do_load(8'h01, d, 0, 0, 1'b0, "recover");

      // Length one past the limit, then exactly at the limit.
      do_load(8'd129, d, 0, 0, 1'b0, "len_129");
      d = {};
      for (int i = 0; i < 256; i++) d.push_back(8'($urandom));
      do_load(8'd128, d, 0, 0, 1'b0, "len_128");

      // Stalled stream: two idle cycles before every byte.
      d = {};
      for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
      do_load(8'h03, d, 2, 2, 1'b0, "stall");

`ifdef PROG_LOADER_CHECKSUM_EN
      d = '{8'h34, 8'h12};
      do_load(8'h01, d, 0, 0, 1'b0, "csum_good");
      do_load(8'h01, d, 0, 0, 1'b1, "csum_bad");
`endif

      // Reset in the cycle the first word is being written.
      pulse_start("mid_rst");
      send_byte(8'h02, 0, "mid_rst");
      send_byte(8'h10, 0, "mid_rst");
      send_byte(8'h05, 0, "mid_rst");
      chk("mid_rst_we_before", 32'(im_we_a), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      d = '{8'hEF, 8'hBE};
      do_load(8'h01, d, 0, 0, 1'b0, "post_rst");

      // Randomized loads, including invalid lengths and random stalls.
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(9, 0);
         if (r == 0)      n = 8'h00;
         else if (r == 1) n = 8'($urandom_range(255, 129));
         else             n = 8'($urandom_range(8, 1));
         d = {};
         for (int i = 0; i < 2 * int'(n); i++) d.push_back(8'($urandom));
         do_load(n, d, 0, 2, 1'($urandom_range(1, 0)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
